detect_controller: RTL and testbench

//  Parametrised successor to the fixed three-input ll/ps/ne decision path.

---
 rtl/detect_controller_pkg.sv | 31 +++
 rtl/detect_controller_feat_channel.sv | 50 +++++
 rtl/detect_controller.sv | 157 +++++++++++++++
 tb/tb_detect_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_controller_pkg.sv
// Shared definitions for the detection controller: state encodings, default widths
// common with the ll/ps/ne feature modules, and small elaboration-time helpers.
package detect_controller_pkg;

  localparam int DEF_NUM_FEAT   = 3;
  localparam int DEF_FEAT_WIDTH = 40;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STIM    = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/detect_controller_feat_channel.sv
// One feature channel: programmable threshold, strict signed compare, and the
// hit/seen flags for the current epoch with sticky overrun detection.
module detect_controller_feat_channel
  import detect_controller_pkg::*;
#(
  parameter int                            FEAT_WIDTH  = DEF_FEAT_WIDTH,
  parameter logic signed [FEAT_WIDTH-1:0]  THR_DEFAULT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          feat_valid,
  input  logic signed [FEAT_WIDTH-1:0]  feat,
  input  logic                          thr_load,
  input  logic signed [FEAT_WIDTH-1:0]  thr_data,
  input  logic                          clear,
  output logic                          hit,
  output logic                          seen_live,
  output logic                          overrun
);

  logic signed [FEAT_WIDTH-1:0] thr;
  logic                         seen;

  // During the epoch-clearing cycle the old seen flag no longer belongs to an open epoch
  assign seen_live = seen & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr     <= THR_DEFAULT;
      hit     <= 1'b0;
      seen    <= 1'b0;
      overrun <= 1'b0;
    end else if (!en) begin
      if (thr_load) begin
        thr <= thr_data;
      end
      if (feat_valid) begin
        hit  <= (feat > thr);
        seen <= 1'b1;
        if (seen_live) begin
          overrun <= 1'b1;
        end
      end else if (clear) begin
        seen <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/detect_controller.sv
// k-of-N epoch voter with persistence, timed stimulation pulse and refractory lockout,
// sitting between the feature channels and the stimulation pin.
module detect_controller
  import detect_controller_pkg::*;
#(
  parameter int                            NUM_FEAT    = DEF_NUM_FEAT,
  parameter int                            FEAT_WIDTH  = DEF_FEAT_WIDTH,
  parameter int                            VOTE_MIN    = 2,
  parameter int                            PERSIST     = 3,
  parameter int                            STIM_LEN    = 4,
  parameter int                            REFRACT_LEN = 8,
  parameter logic signed [FEAT_WIDTH-1:0]  THR_DEFAULT = '0,
  parameter int                            CNT_WIDTH   = DEF_CNT_WIDTH,
  localparam int                           SEL_WIDTH   = max2(1, clog2(NUM_FEAT))
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_FEAT*FEAT_WIDTH-1:0] feat_din,
  input  logic [NUM_FEAT-1:0]            feat_valid,
  input  logic                           thr_wr,
  input  logic [SEL_WIDTH-1:0]           thr_sel,
  input  logic signed [FEAT_WIDTH-1:0]   thr_data,
  output logic                           stimulation,
  output logic [CNT_WIDTH-1:0]           stim_count,
  output logic                           overrun,
  output logic [1:0]                     state
);

  localparam int POP_WIDTH = max2(1, clog2(NUM_FEAT + 1));
  localparam int PER_WIDTH = max2(1, clog2(PERSIST + 1));
  localparam int TMR_WIDTH = max2(1, clog2(max2(STIM_LEN, REFRACT_LEN)));

  localparam logic [TMR_WIDTH-1:0] STIM_LOAD    = TMR_WIDTH'(STIM_LEN - 1);
  localparam logic [TMR_WIDTH-1:0] REFRACT_LOAD = TMR_WIDTH'(REFRACT_LEN - 1);
  localparam logic [PER_WIDTH-1:0] PERSIST_LAST = PER_WIDTH'(PERSIST - 1);
  localparam logic [POP_WIDTH-1:0] VOTE_LIMIT   = POP_WIDTH'(VOTE_MIN);

  logic [NUM_FEAT-1:0]  hit;
  logic [NUM_FEAT-1:0]  seen_live;
  logic [NUM_FEAT-1:0]  ch_overrun;
  logic [NUM_FEAT-1:0]  thr_load;
  logic                 epoch_close;
  logic                 close_q;
  logic [POP_WIDTH-1:0] hit_count;
  logic                 pass;

  state_t               cur_state;
  state_t               nxt_state;
  logic [TMR_WIDTH-1:0] timer;
  logic [TMR_WIDTH-1:0] nxt_timer;
  logic [PER_WIDTH-1:0] persist;
  logic [PER_WIDTH-1:0] nxt_persist;
  logic [CNT_WIDTH-1:0] stim_cnt;
  logic [CNT_WIDTH-1:0] nxt_cnt;

  for (genvar g = 0; g < NUM_FEAT; g++) begin : g_ch
    assign thr_load[g] = thr_wr && (thr_sel == SEL_WIDTH'(g));

    detect_controller_feat_channel #(
      .FEAT_WIDTH  (FEAT_WIDTH),
      .THR_DEFAULT (THR_DEFAULT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .feat_valid (feat_valid[g]),
      .feat       (feat_din[g*FEAT_WIDTH +: FEAT_WIDTH]),
      .thr_load   (thr_load[g]),
      .thr_data   (thr_data),
      .clear      (close_q),
      .hit        (hit[g]),
      .seen_live  (seen_live[g]),
      .overrun    (ch_overrun[g])
    );
  end

  // An epoch closes once every channel has reported, counting valids arriving this cycle
  assign epoch_close = &(seen_live | feat_valid);

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      hit_count = hit_count + POP_WIDTH'(hit[i]);
    end
  end

  assign pass = (hit_count >= VOTE_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= ST_IDLE;
      timer     <= '0;
      persist   <= '0;
      stim_cnt  <= '0;
      close_q   <= 1'b0;
    end else if (!en) begin
      cur_state <= nxt_state;
      timer     <= nxt_timer;
      persist   <= nxt_persist;
      stim_cnt  <= nxt_cnt;
      close_q   <= epoch_close;
    end
  end

  // Epoch results only count while idle; STIM and REFRACT just run their timers down
  always_comb begin
    nxt_state   = cur_state;
    nxt_timer   = timer;
    nxt_persist = persist;
    nxt_cnt     = stim_cnt;
    unique case (cur_state)
      ST_IDLE: begin
        if (close_q) begin
          if (!pass) begin
            nxt_persist = '0;
          end else if (persist == PERSIST_LAST) begin
            nxt_state   = ST_STIM;
            nxt_timer   = STIM_LOAD;
            nxt_persist = '0;
            if (stim_cnt != '1) begin
              nxt_cnt = stim_cnt + 1'b1;
            end
          end else begin
            nxt_persist = persist + 1'b1;
          end
        end
      end
      ST_STIM: begin
        if (timer == '0) begin
          nxt_state = ST_REFRACT;
          nxt_timer = REFRACT_LOAD;
        end else begin
          nxt_timer = timer - 1'b1;
        end
      end
      ST_REFRACT: begin
        if (timer == '0) begin
          nxt_state = ST_IDLE;
        end else begin
          nxt_timer = timer - 1'b1;
        end
      end
      default: begin
        nxt_state   = ST_IDLE;
        nxt_timer   = '0;
        nxt_persist = '0;
      end
    endcase
  end

  assign stimulation = (cur_state == ST_STIM) && !en;
  assign stim_count  = stim_cnt;
  assign overrun     = |ch_overrun;
  assign state       = cur_state;

endmodule

// File: tb/tb_detect_controller.sv
// Bench for detect_controller: hand-derived vector table, directed corner sequences,
// and random traffic checked against an epoch-level reference model.
module tb_detect_controller;

  localparam int NF   = 3;
  localparam int FW   = 40;
  localparam int VOTE = 2;
  localparam int PERS = 3;
  localparam int SLEN = 4;
  localparam int RLEN = 8;
  localparam int CW   = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    en  = 1'b0;
  logic [NF*FW-1:0]        feat_din = '0;
  logic [NF-1:0]           feat_valid = '0;
  logic                    thr_wr = 1'b0;
  logic [1:0]              thr_sel = '0;
  logic signed [FW-1:0]    thr_data = '0;
  logic                    stimulation;
  logic [CW-1:0]           stim_count;
  logic                    overrun;
  logic [1:0]              state;

  int errors = 0;
  int checks = 0;

  logic signed [FW-1:0] m_thr [NF];
  bit  m_seen [NF];
  bit  m_hit  [NF];
  bit  m_pending;
  bit  m_overrun;
  int  m_persist;
  int  m_phase;
  int  m_left;
  int  m_count;

  typedef struct {
    logic [NF-1:0] valid;
    int            f0;
    int            f1;
    int            f2;
    logic          stim;
    int            st;
    int            cnt;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  detect_controller #(
    .NUM_FEAT    (NF),
    .FEAT_WIDTH  (FW),
    .VOTE_MIN    (VOTE),
    .PERSIST     (PERS),
    .STIM_LEN    (SLEN),
    .REFRACT_LEN (RLEN),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .feat_din    (feat_din),
    .feat_valid  (feat_valid),
    .thr_wr      (thr_wr),
    .thr_sel     (thr_sel),
    .thr_data    (thr_data),
    .stimulation (stimulation),
    .stim_count  (stim_count),
    .overrun     (overrun),
    .state       (state)
  );

  task automatic modelReset();
    for (int i = 0; i < NF; i++) begin
      m_thr[i]  = '0;
      m_seen[i] = 1'b0;
      m_hit[i]  = 1'b0;
    end
    m_pending = 1'b0;
    m_overrun = 1'b0;
    m_persist = 0;
    m_phase   = 0;
    m_left    = 0;
    m_count   = 0;
  endtask

  // Reference: phase 0 idle, 1 stim, 2 refract; m_left counts remaining enabled cycles
  task automatic modelStep();
    int ones;
    bit open_ep;
    bit all_in;
    if (en) return;
    if (m_pending && m_phase == 0) begin
      ones = 0;
      for (int i = 0; i < NF; i++) ones += int'(m_hit[i]);
      if (ones >= VOTE) begin
        m_persist++;
        if (m_persist == PERS) begin
          m_phase   = 1;
          m_left    = SLEN;
          m_persist = 0;
          if (m_count < (1 << CW) - 1) m_count++;
        end
      end else begin
        m_persist = 0;
      end
    end else if (m_phase != 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_left  = RLEN;
        end else begin
          m_phase = 0;
        end
      end
    end
    all_in = 1'b1;
    for (int i = 0; i < NF; i++) begin
      open_ep = m_seen[i] && !m_pending;
      if (feat_valid[i]) begin
        if (open_ep) m_overrun = 1'b1;
        m_hit[i]  = ($signed(feat_din[i*FW +: FW]) > m_thr[i]);
        m_seen[i] = 1'b1;
      end else begin
        m_seen[i] = open_ep;
      end
      if (!m_seen[i]) all_in = 1'b0;
    end
    m_pending = all_in;
    if (thr_wr && int'(thr_sel) < NF) m_thr[thr_sel] = thr_data;
  endtask

  task automatic applyStimulus(input logic v_en, input logic [NF-1:0] v_valid,
                               input int f0, input int f1, input int f2,
                               input logic v_wr, input logic [1:0] v_sel, input int v_data);
    @(negedge clk);
    en         = v_en;
    feat_valid = v_valid;
    feat_din   = {FW'(f2), FW'(f1), FW'(f0)};
    thr_wr     = v_wr;
    thr_sel    = v_sel;
    thr_data   = FW'(v_data);
    @(posedge clk);
    #1;
    modelStep();
  endtask

  task automatic checkOutput(input string name, input logic e_stim, input int e_state,
                             input int e_cnt, input logic e_ovr);
    checks++;
    if (stimulation !== e_stim) begin
      errors++;
      $display("[TB] FAIL %s stimulation got=%b exp=%b", name, stimulation, e_stim);
    end
    checks++;
    if (state !== 2'(e_state)) begin
      errors++;
      $display("[TB] FAIL %s state got=%0d exp=%0d", name, state, e_state);
    end
    checks++;
    if (stim_count !== CW'(e_cnt)) begin
      errors++;
      $display("[TB] FAIL %s stim_count got=%0d exp=%0d", name, stim_count, e_cnt);
    end
    checks++;
    if (overrun !== e_ovr) begin
      errors++;
      $display("[TB] FAIL %s overrun got=%b exp=%b", name, overrun, e_ovr);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, (m_phase == 1) && !en, m_phase, m_count, m_overrun);
  endtask

  task automatic tick(input string name, input logic [NF-1:0] v, input int f0,
                      input int f1, input int f2);
    applyStimulus(1'b0, v, f0, f1, f2, 1'b0, 2'd0, 0);
    checkModel(name);
  endtask

  task automatic run_epoch(input string name, input int f0, input int f1, input int f2);
    tick(name, 3'b001, f0, 0, 0);
    tick(name, 3'b010, 0, f1, 0);
    tick(name, 3'b100, 0, 0, f2);
  endtask

  task automatic run_idle(input string name, input int n);
    for (int i = 0; i < n; i++) tick(name, 3'b000, 0, 0, 0);
  endtask

  task automatic program_thr(input int value);
    for (int i = 0; i < NF; i++) begin
      applyStimulus(1'b0, '0, 0, 0, 0, 1'b1, 2'(i), value);
      checkModel("thr_prog");
    end
  endtask

  // Reset asserts at a negedge and must clear outputs without waiting for a clock edge
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    en         = 1'b0;
    feat_valid = '0;
    feat_din   = '0;
    thr_wr     = 1'b0;
    thr_sel    = '0;
    thr_data   = '0;
    #1;
    modelReset();
    checkOutput("reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int r = 0; r < 22; r++) begin
      tbl[r].valid = (r < 9) ? 3'(1 << (r % 3)) : 3'b000;
      tbl[r].f0    = 150;
      tbl[r].f1    = 120;
      tbl[r].f2    = 50;
      tbl[r].stim  = (r >= 9 && r <= 12);
      tbl[r].st    = (r < 9) ? 0 : (r <= 12) ? 1 : (r <= 20) ? 2 : 0;
      tbl[r].cnt   = (r >= 9) ? 1 : 0;
    end

    do_reset();
    program_thr(100);

    for (int r = 0; r < 22; r++) begin
      applyStimulus(1'b0, tbl[r].valid, tbl[r].f0, tbl[r].f1, tbl[r].f2, 1'b0, 2'd0, 0);
      checkOutput($sformatf("vec%0d", r), tbl[r].stim, tbl[r].st, tbl[r].cnt, 1'b0);
    end

    do_reset();
    program_thr(100);
    run_epoch("s2", 150, 120, 50);
    run_epoch("s2", 150, 120, 50);
    run_epoch("s2", 150, 50, 50);
    run_epoch("s2", 150, 120, 50);
    run_idle("s2", 3);
    checkOutput("s2_no_stim", 1'b0, 0, 0, 1'b0);

    do_reset();
    program_thr(100);
    for (int e = 0; e < 6; e++) run_epoch("s3", 150, 120, 50);
    checkOutput("s3_in_refract", 1'b0, 2, 1, 1'b0);
    run_idle("s3", 5);
    run_epoch("s3", 150, 120, 50);
    run_epoch("s3", 150, 120, 50);
    checkOutput("s3_persist_restart", 1'b0, 0, 1, 1'b0);
    run_epoch("s3", 150, 120, 50);
    run_idle("s3", 1);
    checkOutput("s3_second_pulse", 1'b1, 1, 2, 1'b0);

    do_reset();
    program_thr(100);
    run_epoch("s4", 150, 120, 50);
    run_epoch("s4", 150, 120, 50);
    tick("s4", 3'b001, 150, 0, 0);
    tick("s4", 3'b010, 0, 50, 0);
    tick("s4", 3'b010, 0, 120, 0);
    checkOutput("s4_overrun_set", 1'b0, 0, 0, 1'b1);
    tick("s4", 3'b100, 0, 0, 50);
    run_idle("s4", 1);
    checkOutput("s4_second_value_used", 1'b1, 1, 1, 1'b1);
    run_idle("s4", 10);
    checkOutput("s4_overrun_sticky", 1'b0, 2, 1, 1'b1);

    do_reset();
    program_thr(100);
    run_epoch("s5", 150, 120, 50);
    run_epoch("s5", 150, 120, 50);
    tick("s5", 3'b001, 150, 0, 0);
    tick("s5", 3'b010, 0, 50, 0);
    applyStimulus(1'b0, 3'b100, 0, 0, 50, 1'b1, 2'd2, 40);
    checkModel("s5_wr");
    run_idle("s5", 1);
    checkOutput("s5_old_thr_miss", 1'b0, 0, 0, 1'b0);
    for (int e = 0; e < 3; e++) run_epoch("s5", 150, 50, 50);
    run_idle("s5", 1);
    checkOutput("s5_new_thr_hit", 1'b1, 1, 1, 1'b0);

    do_reset();
    program_thr(100);
    for (int e = 0; e < 3; e++) run_epoch("s6", 150, 120, 50);
    run_idle("s6", 2);
    checkOutput("s6_stim_cycle2", 1'b1, 1, 1, 1'b0);
    do_reset();
    program_thr(100);
    for (int e = 0; e < 3; e++) run_epoch("s6en", 150, 120, 50);
    run_idle("s6en", 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'b111, 150, 120, 50, 1'b1, 2'd0, 500);
      checkOutput("s6_masked", 1'b0, 1, 1, 1'b0);
    end
    run_idle("s6en", 2);
    checkOutput("s6_resumed", 1'b1, 1, 1, 1'b0);
    run_idle("s6en", 1);
    checkOutput("s6_refract", 1'b0, 2, 1, 1'b0);

    do_reset();
    program_thr(100);
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 9) == 0),
                    {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0)},
                    int'($urandom_range(0, 300)) - 100,
                    int'($urandom_range(0, 300)) - 100,
                    int'($urandom_range(0, 300)) - 100,
                    ($urandom_range(0, 19) == 0),
                    2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 200)) - 20);
      checkModel("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
